// File: rtl/cram_st_addr_gen.sv
// Store address generator for one CRAM bank. Captures length/stride/base from
// configuration strobes, then issues one write enable plus address per accepted
// store request, stepping the address by the stride until the length runs out.
module cram_st_addr_gen #(
  parameter int unsigned WIDTH_DATA   = 32,
  parameter int unsigned WIDTH_ADDR   = 10,
  parameter int unsigned WIDTH_LENGTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Set_Config,
  input  logic                    I_We_Length,
  input  logic                    I_We_Stride,
  input  logic                    I_We_Base,
  input  logic [WIDTH_DATA-1:0]   I_Data,
  input  logic                    I_Req,
  input  logic                    I_Nack,
  input  logic                    I_Trm,
  output logic                    O_We,
  output logic [WIDTH_ADDR-1:0]   O_Addr,
  output logic                    O_AccessEnd,
  output logic                    O_Busy,
  output logic [WIDTH_LENGTH-1:0] O_Remain
);

  typedef enum logic [1:0] {
    StIdle,
    StConfig,
    StRun,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH_LENGTH-1:0] length_q, length_d;
  logic [WIDTH_ADDR-1:0]   stride_q, stride_d;
  logic [WIDTH_ADDR-1:0]   base_q, base_d;
  logic [WIDTH_ADDR-1:0]   addr_q, addr_d;
  logic [WIDTH_LENGTH-1:0] count_q, count_d;

  logic                    write;
  logic [WIDTH_LENGTH-1:0] length_new;

  // base_q is kept as an architectural copy of the programmed base; the start
  // address is loaded straight from the bus, so the stored copy is not read.
  logic unused_data;
  assign unused_data = ^{I_Data, base_q};

  // Length seen by a base strobe: a length strobe in the same cycle takes effect.
  always_comb begin
    length_new = length_q;
    if (I_We_Length) begin
      length_new = I_Data[WIDTH_LENGTH-1:0];
    end
  end

  // A write happens only in RUN with a request that is neither stalled nor aborted.
  always_comb begin
    write = (state_q == StRun) & I_Req & ~I_Nack & ~I_Trm;
  end

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    stride_d = stride_q;
    base_d   = base_q;
    addr_d   = addr_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (I_Set_Config) begin
          state_d = StConfig;
        end
      end

      StConfig: begin
        if (I_Trm) begin
          state_d = StIdle;
        end else begin
          if (I_We_Length) begin
            length_d = I_Data[WIDTH_LENGTH-1:0];
          end
          if (I_We_Stride) begin
            stride_d = I_Data[WIDTH_ADDR-1:0];
          end
          if (I_We_Base) begin
            base_d  = I_Data[WIDTH_ADDR-1:0];
            addr_d  = I_Data[WIDTH_ADDR-1:0];
            count_d = length_new;
            state_d = (length_new != '0) ? StRun : StDone;
          end
        end
      end

      StRun: begin
        if (I_Trm) begin
          state_d = StIdle;
        end else if (write) begin
          // Address wraps silently at the top of the address space.
          addr_d  = addr_q + stride_q;
          count_d = count_q - WIDTH_LENGTH'(1);
          if (count_q == WIDTH_LENGTH'(1)) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and configuration registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      length_q <= '0;
      stride_q <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      stride_q <= stride_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
    end
  end

  // Output decode; the remaining count is only meaningful while running.
  always_comb begin
    O_We        = write;
    O_Addr      = addr_q;
    O_AccessEnd = (state_q == StDone);
    O_Busy      = (state_q == StConfig) || (state_q == StRun);
    O_Remain    = (state_q == StRun) ? count_q : '0;
  end

endmodule
